// File: rtl/iq_sample_pacer_if.sv
// FIFO read port between the transmit FIFO and the IQ sample pacer.
// The master is the pacer, which pops bytes. The slave is the FIFO.
interface iq_sample_pacer_if;
    logic       fifo_empty;
    logic [7:0] fifo_data_out;
    logic       fifo_rd;

    modport master (input fifo_empty, input fifo_data_out, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_data_out, input fifo_rd);
endinterface

// File: rtl/iq_sample_pacer.sv
// Pulls I/Q byte pairs from the transmit FIFO into a staging buffer.
// Each pair is released to the modulator on a programmable sample tick, and missed ticks are flagged.
module iq_sample_pacer #(
    parameter int DIV_W  = 16,
    parameter int UCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DIV_W-1:0]    rate_div,
    iq_sample_pacer_if.master   fifo,
    output logic [7:0]          sample_i,
    output logic [7:0]          sample_q,
    output logic                sample_stb,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_count
);
    typedef enum logic [2:0] {FETCH_I, CAP_I, FETCH_Q, CAP_Q, FULL} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              primed_q, primed_d;
    logic [7:0]        stage_i_q, stage_i_d, stage_q_q, stage_q_d;
    logic [7:0]        sample_i_q, sample_i_d, sample_q_q, sample_q_d;
    logic              sample_stb_q, sample_stb_d, underrun_q, underrun_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic              tick;
    logic              fetch_req;

    assign tick      = enable && (cnt_q == '0);
    assign fetch_req = !fifo.fifo_empty && (state_q == FETCH_I || state_q == FETCH_Q);
    // Reset is asynchronous, so the read strobe must also be held off while reset is held.
    assign fifo.fifo_rd = rst && fetch_req;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        primed_d     = primed_q;
        stage_i_d    = stage_i_q;
        stage_q_d    = stage_q_q;
        sample_i_d   = sample_i_q;
        sample_q_d   = sample_q_q;
        sample_stb_d = 1'b0;
        underrun_d   = 1'b0;
        ucnt_d       = ucnt_q;

        // The fetch side runs even while disabled, so one pair can be prefetched.
        case (state_q)
            FETCH_I: if (fetch_req) state_d = CAP_I;
            CAP_I: begin
                stage_i_d = fifo.fifo_data_out;
                state_d   = FETCH_Q;
            end
            FETCH_Q: if (fetch_req) state_d = CAP_Q;
            CAP_Q: begin
                stage_q_d = fifo.fifo_data_out;
                state_d   = FULL;
            end
            FULL: if (tick) state_d = FETCH_I;
            default: state_d = FETCH_I;
        endcase

        if (!enable || tick) cnt_d = rate_div;
        else                 cnt_d = cnt_q - DIV_W'(1);

        if (!enable) begin
            sample_i_d = 8'h00;
            sample_q_d = 8'h00;
            primed_d   = 1'b0;
        end else if (tick) begin
            if (state_q == FULL) begin
                sample_i_d   = stage_i_q;
                sample_q_d   = stage_q_q;
                sample_stb_d = 1'b1;
                primed_d     = 1'b1;
            end else begin
                // The baseband is silenced on a starved tick. Only a primed stream counts it as an underrun.
                sample_i_d = 8'h00;
                sample_q_d = 8'h00;
                if (primed_q) begin
                    underrun_d = 1'b1;
                    if (ucnt_q != '1) ucnt_d = ucnt_q + UCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH_I;
            cnt_q        <= '0;
            primed_q     <= 1'b0;
            stage_i_q    <= 8'h00;
            stage_q_q    <= 8'h00;
            sample_i_q   <= 8'h00;
            sample_q_q   <= 8'h00;
            sample_stb_q <= 1'b0;
            underrun_q   <= 1'b0;
            ucnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            primed_q     <= primed_d;
            stage_i_q    <= stage_i_d;
            stage_q_q    <= stage_q_d;
            sample_i_q   <= sample_i_d;
            sample_q_q   <= sample_q_d;
            sample_stb_q <= sample_stb_d;
            underrun_q   <= underrun_d;
            ucnt_q       <= ucnt_d;
        end
    end

    assign sample_i       = sample_i_q;
    assign sample_q       = sample_q_q;
    assign sample_stb     = sample_stb_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucnt_q;
endmodule

// File: tb/tb_iq_sample_pacer.sv
// Directed bench for iq_sample_pacer.
// A behavioural FIFO feeds the pacer, and outputs are checked against hand-computed vectors.
module tb_iq_sample_pacer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] rate_div = 16'd9;
    logic [7:0]  sample_i, sample_q, underrun_count;
    logic        sample_stb, underrun;

    iq_sample_pacer_if pif();

    iq_sample_pacer #(.DIV_W(16), .UCNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rate_div(rate_div), .fifo(pif.master),
        .sample_i(sample_i), .sample_q(sample_q), .sample_stb(sample_stb),
        .underrun(underrun), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr;
    int rd_count = 0;
    int bad_rd = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    assign pif.fifo_empty = (wr_ptr == rd_ptr);

    // The FIFO model returns read data on the cycle after fifo_rd.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr            <= 0;
            pif.fifo_data_out <= 8'h00;
        end else if (pif.fifo_rd) begin
            pif.fifo_data_out <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (rst && pif.fifo_rd) begin
            rd_count = rd_count + 1;
            if (pif.fifo_empty) bad_rd = bad_rd + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic reset_on(input logic en, input logic [15:0] rd);
        @(negedge clk);
        rst = 1'b0;
        enable = en;
        rate_div = rd;
        wr_ptr = 0;
        rd_count = 0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        check("rst_sample_i", {24'd0, sample_i}, 32'h0);
        check("rst_sample_q", {24'd0, sample_q}, 32'h0);
        check("rst_stb_ur", {30'd0, sample_stb, underrun}, 32'h0);
        check("rst_ucnt", {24'd0, underrun_count}, 32'h0);
        check("rst_fifo_rd", {31'd0, pif.fifo_rd}, 32'h0);
        rst = 1'b1;
        cyc = 0;
    endtask

    typedef struct {
        int         cyc;
        bit         push;
        int         rdn;
        logic       stb;
        logic [7:0] i;
        logic [7:0] q;
        logic       ur;
        logic [7:0] ucnt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int pulses, stbs, prev;
        bit found, wrapped;

        vecs[0]  = '{10, 0, -1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd0};
        vecs[1]  = '{11, 0, -1, 1'b1, 8'h11, 8'h22, 1'b0, 8'd0};
        vecs[2]  = '{12, 0, -1, 1'b0, 8'h11, 8'h22, 1'b0, 8'd0};
        vecs[3]  = '{20, 0,  4, 1'b0, 8'h11, 8'h22, 1'b0, 8'd0};
        vecs[4]  = '{21, 0, -1, 1'b1, 8'h33, 8'h44, 1'b0, 8'd0};
        vecs[5]  = '{30, 0,  4, 1'b0, 8'h33, 8'h44, 1'b0, 8'd0};
        vecs[6]  = '{31, 0, -1, 1'b0, 8'h00, 8'h00, 1'b1, 8'd1};
        vecs[7]  = '{32, 1, -1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd1};
        vecs[8]  = '{40, 0, -1, 1'b0, 8'h00, 8'h00, 1'b0, 8'd1};
        vecs[9]  = '{41, 0, -1, 1'b1, 8'h55, 8'h66, 1'b0, 8'd1};
        vecs[10] = '{42, 0,  6, 1'b0, 8'h55, 8'h66, 1'b0, 8'd1};

        // Scenario 1: preloaded stream, then FIFO runs dry, then it is refilled.
        reset_on(1'b1, 16'd9);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        release_rst();
        foreach (vecs[k]) begin
            while (cyc < vecs[k].cyc) step();
            check("vec_stb", {31'd0, sample_stb}, {31'd0, vecs[k].stb});
            check("vec_i", {24'd0, sample_i}, {24'd0, vecs[k].i});
            check("vec_q", {24'd0, sample_q}, {24'd0, vecs[k].q});
            check("vec_underrun", {31'd0, underrun}, {31'd0, vecs[k].ur});
            check("vec_ucnt", {24'd0, underrun_count}, {24'd0, vecs[k].ucnt});
            if (vecs[k].rdn >= 0) check("vec_rd_count", rd_count, vecs[k].rdn);
            if (vecs[k].push) begin push(8'h55); push(8'h66); end
        end
        enable = 1'b0;
        repeat (5) step();
        check("disable_ucnt_kept", {24'd0, underrun_count}, 32'd1);
        check("disable_zero_i", {24'd0, sample_i}, 32'h0);

        // Scenario 2: lone I byte, then Q arrives 30 cycles later.
        reset_on(1'b1, 16'd9);
        release_rst();
        push(8'h7F);
        stbs = 0;
        repeat (30) begin step(); if (sample_stb) stbs++; end
        check("half_pair_rd_count", rd_count, 1);
        check("half_pair_no_stb", stbs, 0);
        push(8'h80);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (sample_stb) found = 1;
        end
        check("pair_7f_stb_seen", {31'd0, found}, 32'd1);
        check("pair_7f_cycle", cyc, 41);
        check("pair_7f_i", {24'd0, sample_i}, 32'h7F);
        check("pair_7f_q", {24'd0, sample_q}, 32'h80);
        check("pair_7f_rd_count", rd_count, 2);
        check("pair_7f_ucnt", {24'd0, underrun_count}, 32'd0);

        // Scenario 3: period shorter than the fill, so the underrun count saturates.
        reset_on(1'b1, 16'd2);
        for (int k = 0; k < 700; k++) push(8'(k));
        release_rst();
        pulses = 0;
        prev = 0;
        wrapped = 0;
        repeat (1800) begin
            step();
            if (underrun) pulses++;
            if (int'(underrun_count) < prev) wrapped = 1;
            prev = int'(underrun_count);
        end
        check("sat_pulses_ge_256", {31'd0, (pulses >= 256)}, 32'd1);
        check("sat_ucnt", {24'd0, underrun_count}, 32'hFF);
        check("sat_no_wrap", {31'd0, wrapped}, 32'd0);

        // Scenario 4: start-up with an empty FIFO must stay silent.
        reset_on(1'b1, 16'd9);
        release_rst();
        pulses = 0;
        stbs = 0;
        repeat (50) begin
            step();
            if (underrun) pulses++;
            if (sample_stb) stbs++;
        end
        check("startup_no_underrun", pulses, 0);
        check("startup_no_stb", stbs, 0);
        check("startup_ucnt", {24'd0, underrun_count}, 32'd0);
        check("startup_out", {16'd0, sample_i, sample_q}, 32'h0);

        // Scenario 5: disable with a staged pair, re-enable, then an asynchronous reset.
        reset_on(1'b1, 16'd9);
        push(8'h01); push(8'h02); push(8'h0A); push(8'h0B);
        release_rst();
        while (cyc < 11) step();
        check("pre_disable_stb", {31'd0, sample_stb}, 32'd1);
        check("pre_disable_pair", {16'd0, sample_i, sample_q}, 32'h0102);
        while (cyc < 16) step();
        enable = 1'b0;
        step();
        check("disable_out_zero", {16'd0, sample_i, sample_q}, 32'h0);
        stbs = 0;
        repeat (30) begin step(); if (sample_stb) stbs++; end
        check("disabled_no_stb", stbs, 0);
        enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k < 10) check("reenable_wait_stb", {31'd0, sample_stb}, 32'd0);
        end
        check("reenable_stb", {31'd0, sample_stb}, 32'd1);
        check("reenable_pair", {16'd0, sample_i, sample_q}, 32'h0A0B);
        check("reenable_no_underrun", {31'd0, underrun}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out", {16'd0, sample_i, sample_q}, 32'h0);
        check("async_rst_stb", {31'd0, sample_stb}, 32'd0);
        check("async_rst_ucnt", {24'd0, underrun_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("rd_never_when_empty", bad_rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
